gate_tt_checker: RTL and testbench

- Sequential stimulus/response stage wrapped around a combinational gate under test, such as the decoder-built NAND/NOR gates.
- Drives every input combination onto the gate's inputs and waits a programmable settle time.
- Samples the gate output, builds the captured truth table and compares it against an expected table.
- Replaces hand-timed #10 stimulus with a clocked, self-checking sequencer usable in simulation and on the board.

---
 rtl/gate_chk_pkg.sv | 20 ++
 rtl/gate_tt_checker_settle_timer.sv | 35 +++
 rtl/gate_tt_checker.sv | 152 +++++++++++++++
 tb/tb_gate_tt_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: state encoding and
// reference truth tables for common two-input gates.
package gate_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Bit i is the gate output for stim == i (stim = {a, b}).
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_checker_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag. Load wins over
// decrement; the count stops at zero rather than wrapping.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, decrement toward zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps every input combination onto a combinational gate,
// holds each for SETTLE cycles, samples the output and compares the captured
// truth table against EXP_TT.
// Optional build macro GATE_TT_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching vector instead of completing all vectors.
//
// Handshake: start is a single-cycle request, accepted only while idle and
// never queued; busy covers the sweep, done pulses for one cycle at its end,
// and all result outputs hold until the next accepted start.
module gate_tt_checker
  import gate_chk_pkg::*;
#(
  parameter int                N_IN   = 2,
  parameter logic [2**N_IN-1:0] EXP_TT = 4'b0111,
  parameter int                SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_IN-1:0]     stim,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     first_fail_idx,
  output logic [2**N_IN-1:0]  captured_tt,
  output logic [1:0]          dbg_state
);

  localparam int             CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  RELOAD   = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX = '1;
`ifdef GATE_TT_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [N_IN:0]       err_q, err_d;
  logic [N_IN-1:0]     ffi_q, ffi_d;
  logic [2**N_IN-1:0]  cap_q, cap_d;
  logic                pass_q, pass_d;
  logic                timer_load, timer_dec, timer_zero;
  logic                mismatch, last_vec;

  assign mismatch = (dut_out != EXP_TT[idx_q]);
  assign last_vec = (idx_q == LAST_IDX);

  settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (timer_zero) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        if (last_vec || (STOP_ON_FAIL && mismatch)) state_d = ST_DONE;
        else                                        state_d = ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Datapath next values: vector index, capture, error tracking, verdict.
  always_comb begin
    idx_d      = idx_q;
    err_d      = err_q;
    ffi_d      = ffi_q;
    cap_d      = cap_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d      = '0;
          err_d      = '0;
          ffi_d      = '0;
          cap_d      = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: timer_dec = 1'b1;
      ST_SAMPLE: begin
        cap_d[idx_q] = dut_out;
        if (mismatch) begin
          err_d = err_q + (N_IN+1)'(1);
          if (err_q == '0) ffi_d = idx_q;
        end
        if (state_d == ST_DONE) begin
          // Verdict uses the count including this last sample.
          pass_d = (err_d == '0);
        end else begin
          idx_d      = idx_q + N_IN'(1);
          timer_load = 1'b1;
        end
      end
      ST_DONE: idx_d = '0;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      err_q  <= '0;
      ffi_q  <= '0;
      cap_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      err_q  <= err_d;
      ffi_q  <= ffi_d;
      cap_q  <= cap_d;
      pass_q <= pass_d;
    end
  end

  assign stim           = idx_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign captured_tt    = cap_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker with default parameters (2-input NAND
// expected, SETTLE=2). A small behavioural gate model selected by gate_mode
// drives dut_out from stim.
module tb_gate_tt_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] stim;
  logic       dut_out;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_fail_idx;
  logic [3:0] captured_tt;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int gate_mode = 0; // 0 NAND, 1 AND, 2 tied 1, 3 tied 0

`ifdef GATE_TT_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  gate_tt_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stim           (stim),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .captured_tt    (captured_tt),
    .dbg_state      (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Gate model.
  always_comb begin
    dut_out = 1'b0;
    case (gate_mode)
      0: dut_out = ~(stim[1] & stim[0]);
      1: dut_out = stim[1] & stim[0];
      2: dut_out = 1'b1;
      default: dut_out = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then watch 20 cycles: report first done cycle and done count.
  task automatic run_sweep(input int reassert_at, input bit check_stim,
                           output int lat, output int n_done);
    lat = -1;
    n_done = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int c = 1; c <= 20; c++) begin
      if (c == reassert_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (check_stim && c < 12) check("stim_seq", 32'(stim), 32'(c / 3));
      if (done) begin
        n_done++;
        if (lat < 0) begin
          lat = c;
          check("busy_in_done", 32'(busy), 32'd0);
        end
      end
    end
  endtask

  task automatic check_results(input string tag, input logic [3:0] cap,
                               input logic [2:0] ec, input logic [1:0] ffi,
                               input logic ps);
    check({tag, "_captured"}, 32'(captured_tt), 32'(cap));
    check({tag, "_err_count"}, 32'(err_count), 32'(ec));
    check({tag, "_first_fail"}, 32'(first_fail_idx), 32'(ffi));
    check({tag, "_pass"}, 32'(pass), 32'(ps));
  endtask

  initial begin
    int lat, nd, guard;

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_outputs", {stim, busy, done, pass, err_count, first_fail_idx, captured_tt},
          32'd0);
    rst_n = 1'b1;
    tick();

    // Clean NAND sweep with stim sequence check.
    gate_mode = 0;
    run_sweep(0, 1'b1, lat, nd);
    check("nand_latency", 32'(lat), 32'd12);
    check("nand_done_count", 32'(nd), 32'd1);
    check_results("nand", 4'b0111, 3'd0, 2'd0, 1'b1);
    check("idle_stim", 32'(stim), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);

    // AND gate against a NAND table.
    gate_mode = 1;
    run_sweep(0, 1'b0, lat, nd);
    check("and_latency", 32'(lat), STOP ? 32'd3 : 32'd12);
    check_results("and", STOP ? 4'b0000 : 4'b1000, STOP ? 3'd1 : 3'd4, 2'd0, 1'b0);

    // Output stuck at 1: only the last vector is wrong.
    gate_mode = 2;
    run_sweep(0, 1'b0, lat, nd);
    check("tie1_latency", 32'(lat), 32'd12);
    check_results("tie1", 4'b1111, 3'd1, 2'd3, 1'b0);

    // Start reasserted mid-sweep is ignored.
    gate_mode = 0;
    run_sweep(5, 1'b0, lat, nd);
    check("restart_latency", 32'(lat), 32'd12);
    check("restart_done_count", 32'(nd), 32'd1);
    check_results("restart", 4'b0111, 3'd0, 2'd0, 1'b1);

    // Reset while idx == 2 aborts without a done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (stim != 2'd2 && guard < 40) begin
      tick();
      guard++;
    end
    check("reach_idx2", 32'(stim), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_outputs", {stim, busy, done, pass, err_count, first_fail_idx, captured_tt},
          32'd0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) nd++;
    end
    check("midrst_no_done", 32'(nd), 32'd0);
    rst_n = 1'b1;
    tick();
    run_sweep(0, 1'b0, lat, nd);
    check("post_rst_latency", 32'(lat), 32'd12);
    check_results("post_rst", 4'b0111, 3'd0, 2'd0, 1'b1);

    // Output stuck at 0: first vector mismatches.
    gate_mode = 3;
    run_sweep(0, 1'b0, lat, nd);
    check("tie0_latency", 32'(lat), STOP ? 32'd3 : 32'd12);
    check_results("tie0", 4'b0000, STOP ? 3'd1 : 3'd3, 2'd0, 1'b0);

    // Results hold while idle.
    tick();
    tick();
    check("hold_err_count", 32'(err_count), STOP ? 32'd1 : 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
